// File: rtl/load_store_unit.sv
// RV32I load/store initiator: converts byte/half/word accesses into word-wide
// memory cycles (read-modify-write for sub-word stores) and rejects bad requests.
module load_store_unit #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic        RSP_ERR,
  output logic [31:0] RSP_RDATA,
  output logic [7:0]  ADDR_DATA_M,
  output logic        Mem_WE,
  output logic [31:0] IN_DATA_M,
  input  logic [31:0] OUT_DATA_M
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic [15:0]     wdata_q;
  logic            capture;

  logic            nxt_rsp_valid, nxt_rsp_err, nxt_mem_we;
  logic [DW-1:0]   nxt_rsp_rdata, nxt_in_data;
  logic [7:0]      nxt_addr_m;

  logic            accept, f3_ok, misaligned, req_err;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [DW-1:0]   ld_val, merge_mask, merged;
  logic [4:0]      shift;

  assign REQ_READY = (state == IDLE) && !RST;
  assign accept    = REQ_VALID && REQ_READY;

  // Request legality, evaluated on the live inputs at accept
  always_comb begin
    f3_ok = 1'b0;
    if (REQ_WE) begin
      f3_ok = (REQ_FUNCT3 == 3'b000) || (REQ_FUNCT3 == 3'b001) || (REQ_FUNCT3 == 3'b010);
    end else begin
      f3_ok = (REQ_FUNCT3 == 3'b000) || (REQ_FUNCT3 == 3'b001) || (REQ_FUNCT3 == 3'b010) ||
              (REQ_FUNCT3 == 3'b100) || (REQ_FUNCT3 == 3'b101);
    end
    misaligned = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                 ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
    req_err    = (REQ_ADDR[31:10] != 22'd0) || !f3_ok || misaligned;
  end

  // Load lane extraction and extension
  always_comb begin
    ld_byte = OUT_DATA_M[7:0];
    case (lane_q)
      2'd0: ld_byte = OUT_DATA_M[7:0];
      2'd1: ld_byte = OUT_DATA_M[15:8];
      2'd2: ld_byte = OUT_DATA_M[23:16];
      2'd3: ld_byte = OUT_DATA_M[31:24];
      default: ld_byte = OUT_DATA_M[7:0];
    endcase
    ld_half = lane_q[1] ? OUT_DATA_M[31:16] : OUT_DATA_M[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = OUT_DATA_M;
    endcase
  end

  // Sub-word store merge into the word just read
  always_comb begin
    shift      = {lane_q, 3'b000};
    merge_mask = f3_q[0] ? (32'h0000_FFFF << shift) : (32'h0000_00FF << shift);
    merged     = (OUT_DATA_M & ~merge_mask) | (({16'd0, wdata_q} << shift) & merge_mask);
  end

  // Next-state and next-output logic
  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_rsp_valid = 1'b0;
    nxt_rsp_err   = 1'b0;
    nxt_rsp_rdata = '0;
    nxt_mem_we    = 1'b0;
    nxt_addr_m    = ADDR_DATA_M;
    nxt_in_data   = IN_DATA_M;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          capture = 1'b1;
          if (req_err) begin
            nxt_state     = DONE;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_err   = 1'b1;
          end else begin
            nxt_addr_m = REQ_ADDR[9:2];
            if (REQ_WE && (REQ_FUNCT3[1:0] == 2'b10)) begin
              nxt_state   = WR;
              nxt_mem_we  = 1'b1;
              nxt_in_data = REQ_WDATA;
            end else begin
              nxt_state = RD;
              nxt_cnt   = CW'(RD_WAIT - 1);
            end
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          if (we_q) begin
            nxt_state   = WR;
            nxt_mem_we  = 1'b1;
            nxt_in_data = merged;
          end else begin
            nxt_state     = DONE;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_rdata = ld_val;
          end
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      WR: begin
        nxt_state     = DONE;
        nxt_rsp_valid = 1'b1;
      end
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      RSP_VALID   <= 1'b0;
      RSP_ERR     <= 1'b0;
      RSP_RDATA   <= '0;
      Mem_WE      <= 1'b0;
      ADDR_DATA_M <= '0;
      IN_DATA_M   <= '0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      RSP_VALID   <= nxt_rsp_valid;
      RSP_ERR     <= nxt_rsp_err;
      RSP_RDATA   <= nxt_rsp_rdata;
      Mem_WE      <= nxt_mem_we;
      ADDR_DATA_M <= nxt_addr_m;
      IN_DATA_M   <= nxt_in_data;
      if (capture) begin
        we_q    <= REQ_WE;
        f3_q    <= REQ_FUNCT3;
        lane_q  <= REQ_ADDR[1:0];
        wdata_q <= REQ_WDATA[15:0];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with RD_WAIT=1, one with
// RD_WAIT=3, each backed by a behavioural word memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, sel;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        rdy1, rsp_valid1, rsp_err1, we_m1;
  logic [31:0] rsp_rdata1, in_m1, out_m1;
  logic [7:0]  addr_m1;
  logic        rdy3, rsp_valid3, rsp_err3, we_m3;
  logic [31:0] rsp_rdata3, in_m3, out_m3;
  logic [7:0]  addr_m3;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.RD_WAIT(1)) u_dut1 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid & ~sel), .REQ_READY(rdy1),
    .REQ_WE(req_we), .REQ_FUNCT3(req_funct3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid1), .RSP_ERR(rsp_err1), .RSP_RDATA(rsp_rdata1),
    .ADDR_DATA_M(addr_m1), .Mem_WE(we_m1), .IN_DATA_M(in_m1), .OUT_DATA_M(out_m1)
  );

  load_store_unit #(.RD_WAIT(3)) u_dut3 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid & sel), .REQ_READY(rdy3),
    .REQ_WE(req_we), .REQ_FUNCT3(req_funct3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid3), .RSP_ERR(rsp_err3), .RSP_RDATA(rsp_rdata3),
    .ADDR_DATA_M(addr_m3), .Mem_WE(we_m3), .IN_DATA_M(in_m3), .OUT_DATA_M(out_m3)
  );

  assign out_m1 = mem1[addr_m1];
  assign out_m3 = mem3[addr_m3];
  always @(posedge clk) if (we_m1) mem1[addr_m1] <= in_m1;
  always @(posedge clk) if (we_m3) mem3[addr_m3] <= in_m3;

  logic        rdy, rsp_valid, rsp_err, we_m;
  logic [31:0] rsp_rdata;
  logic [7:0]  addr_m;
  assign rdy       = sel ? rdy3 : rdy1;
  assign rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign rsp_err   = sel ? rsp_err3 : rsp_err1;
  assign rsp_rdata = sel ? rsp_rdata3 : rsp_rdata1;
  assign we_m      = sel ? we_m3 : we_m1;
  assign addr_m    = sel ? addr_m3 : addr_m1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; latency is counted in cycles after the accept edge
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic err,
                        output logic [31:0] rd, output int pulses, output logic [7:0] waddr);
    lat = -1; err = 1'b0; rd = '0; pulses = 0; waddr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    chk("ready_at_request", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (we_m) begin pulses++; waddr = addr_m; end
      if (rsp_valid) begin lat = k; err = rsp_err; rd = rsp_rdata; break; end
    end
  endtask

  int          lat, pulses, acc, rsp_n, we_n, last_we;
  int          acc_cyc [3];
  logic        err;
  logic [31:0] rd;
  logic [7:0]  wa;
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; sel = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_mem_we", 32'(we_m1), 32'd0);
    chk("rst_addr", 32'(addr_m1), 32'd0);
    chk("rst_in_data", in_m1, 32'd0);
    chk("rst_rdata", rsp_rdata1, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(rdy1), 32'd1);

    // SW then LW
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, err, rd, pulses, wa);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_pulses", 32'(pulses), 32'd1);
    chk("sw_addr", 32'(wa), 32'h04);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_mem", mem1[4], 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, err, rd, pulses, wa);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);

    // SB then LB/LBU
    do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, lat, err, rd, pulses, wa);
    do_req(1'b1, 3'b000, 32'h12, 32'h0000_0080, lat, err, rd, pulses, wa);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_pulses", 32'(pulses), 32'd1);
    chk("sb_mem", mem1[4], 32'h1180_3344);
    do_req(1'b0, 3'b000, 32'h12, 32'h0, lat, err, rd, pulses, wa);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h12, 32'h0, lat, err, rd, pulses, wa);
    chk("lbu_rdata", rd, 32'h0000_0080);
    do_req(1'b0, 3'b000, 32'h10, 32'h0, lat, err, rd, pulses, wa);
    chk("lb_lane0", rd, 32'h0000_0044);

    // SH then LH/LHU
    do_req(1'b1, 3'b010, 32'h14, 32'hAAAA_5555, lat, err, rd, pulses, wa);
    do_req(1'b1, 3'b001, 32'h16, 32'h0000_8001, lat, err, rd, pulses, wa);
    chk("sh_mem", mem1[5], 32'h8001_5555);
    do_req(1'b0, 3'b001, 32'h16, 32'h0, lat, err, rd, pulses, wa);
    chk("lh_rdata", rd, 32'hFFFF_8001);
    do_req(1'b0, 3'b101, 32'h16, 32'h0, lat, err, rd, pulses, wa);
    chk("lhu_rdata", rd, 32'h0000_8001);
    do_req(1'b0, 3'b001, 32'h14, 32'h0, lat, err, rd, pulses, wa);
    chk("lh_lane0", rd, 32'h0000_5555);

    // Rejected accesses
    do_req(1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, lat, err, rd, pulses, wa);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, err, rd, pulses, wa);
    chk("err_lw_mis_lat", 32'(lat), 32'd1);
    chk("err_lw_mis_err", 32'(err), 32'd1);
    chk("err_lw_mis_rdata", rd, 32'd0);
    do_req(1'b1, 3'b001, 32'h11, 32'h0000_FFFF, lat, err, rd, pulses, wa);
    chk("err_sh_mis_err", 32'(err), 32'd1);
    chk("err_sh_mis_pulses", 32'(pulses), 32'd0);
    chk("err_sh_mis_mem", mem1[4], 32'h1180_3344);
    do_req(1'b1, 3'b010, 32'h400, 32'h1234_5678, lat, err, rd, pulses, wa);
    chk("err_sw_range_lat", 32'(lat), 32'd1);
    chk("err_sw_range_err", 32'(err), 32'd1);
    chk("err_sw_range_pulses", 32'(pulses), 32'd0);
    chk("err_sw_range_mem", mem1[0], 32'hCAFE_F00D);
    do_req(1'b1, 3'b100, 32'h10, 32'h0000_0000, lat, err, rd, pulses, wa);
    chk("err_f3_err", 32'(err), 32'd1);
    chk("err_f3_pulses", 32'(pulses), 32'd0);
    chk("err_f3_mem", mem1[4], 32'h1180_3344);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, err, rd, pulses, wa);
    chk("err_ld_f3_err", 32'(err), 32'd1);

    // Reset asserted in the WR cycle of a SW
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h18; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_we_high", 32'(we_m1), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_mem_we", 32'(we_m1), 32'd0);
    chk("rst_wr_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_wr_addr", 32'(addr_m1), 32'd0);
    chk("rst_wr_in_data", in_m1, 32'd0);
    chk("rst_wr_ready", 32'(rdy1), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready_after", 32'(rdy1), 32'd1);
    chk("rst_wr_no_rsp", 32'(rsp_valid1), 32'd0);
    @(negedge clk);
    chk("rst_wr_no_rsp2", 32'(rsp_valid1), 32'd0);

    // RD_WAIT=3, back-to-back SB with REQ_VALID held high
    sel = 1'b1;
    do_req(1'b1, 3'b010, 32'h20, 32'h0, lat, err, rd, pulses, wa);
    chk("w3_sw_lat", 32'(lat), 32'd2);
    b2b_addr[0] = 32'h20; b2b_addr[1] = 32'h21; b2b_addr[2] = 32'h22;
    b2b_data[0] = 32'hA1;  b2b_data[1] = 32'hB2;  b2b_data[2] = 32'hC3;
    acc = 0; rsp_n = 0; we_n = 0; last_we = -100;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = b2b_addr[0]; req_wdata = b2b_data[0];
    for (int c = 0; c < 80 && rsp_n < 3; c++) begin
      if (we_m) begin
        if (we_n > 0) chk("b2b_we_gap", 32'(c - last_we >= 3), 32'd1);
        we_n++;
        last_we = c;
      end
      if (rsp_valid) begin
        chk("b2b_rsp_cycle", 32'(c), 32'(acc_cyc[rsp_n] + 5));
        rsp_n++;
      end
      if (rdy && req_valid && acc < 3) begin
        if (acc > 0) chk("b2b_accept_spacing", 32'(c - acc_cyc[acc-1]), 32'd6);
        acc_cyc[acc] = c;
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 3) begin
        req_addr = b2b_addr[acc]; req_wdata = b2b_data[acc];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_rsp_count", 32'(rsp_n), 32'd3);
    chk("b2b_we_count", 32'(we_n), 32'd3);
    chk("b2b_mem", mem3[8], 32'h00C3_B2A1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, err, rd, pulses, wa);
    chk("w3_lw_lat", 32'(lat), 32'd4);
    chk("w3_lw_rdata", rd, 32'h00C3_B2A1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the RISC-V data memory. Accepts one load or store per request from the MEM stage and drives the word-addressed memory port (`ADDR_DATA_M`, `Mem_WE`, `IN_DATA_M`, `OUT_DATA_M`). It converts RV32I byte, halfword and word accesses into word accesses: read-modify-write for sub-word stores, lane extraction plus sign/zero extension for loads. It rejects misaligned, out-of-range and invalid-funct3 accesses without touching memory.

## Interface
- `RD_WAIT`, 1: cycles `ADDR_DATA_M` is held with `Mem_WE`=0 before `OUT_DATA_M` is sampled; legal range 1..15.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ_VALID`  in  1  request present.
- `REQ_READY`  out  1  unit can accept; equals (state==IDLE && !RST).
- `REQ_WE`  in  1  1 = store, 0 = load.
- `REQ_FUNCT3`  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `REQ_ADDR`  in  32  byte address.
- `REQ_WDATA`  in  32  store data, right-aligned.
- `RSP_VALID`  out  1  one-cycle response pulse.
- `RSP_ERR`  out  1  qualified by `RSP_VALID`; 1 = access rejected.
- `RSP_RDATA`  out  32  load result, extended; 0 for stores and errors.
- `ADDR_DATA_M`  out  8  word address to memory, equal to `REQ_ADDR[9:2]`.
- `Mem_WE`  out  1  memory write enable; registered, glitch-free.
- `IN_DATA_M`  out  32  write data to memory.
- `OUT_DATA_M`  in  32  read data from memory.

## Operation
- States:
  - IDLE: `REQ_READY`=1.
  - RD: read wait, `RD_WAIT` cycles.
  - WR: `Mem_WE`=1 for exactly 1 cycle.
  - DONE: `RSP_VALID`=1 for 1 cycle, then return to IDLE.
- Request capture: on a `REQ_VALID && REQ_READY` edge, latch `REQ_WE`, `REQ_FUNCT3`, `REQ_ADDR`, `REQ_WDATA`. Inputs are don't-care afterwards.
- Error check at accept, all three cause IDLE→DONE with `RSP_ERR`=1 and no memory activity:
  - `REQ_ADDR[31:10]` != 0.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Funct3 not listed above, e.g. store funct3 1xx or load 011/11x.
- Load: IDLE→RD→DONE. `OUT_DATA_M` is sampled at the last RD edge.
  - Byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- SW: IDLE→WR→DONE. `IN_DATA_M` = `REQ_WDATA`.
- SB/SH: IDLE→RD→WR→DONE, read-modify-write.
  - `IN_DATA_M` = the read word with the addressed lane replaced by `REQ_WDATA[7:0]` or `REQ_WDATA[15:0]`.
  - Other lanes are unchanged.
- `ADDR_DATA_M` and `IN_DATA_M` are registered. They are stable for the whole RD/WR window and hold their last value in IDLE/DONE.
- `Mem_WE` rises only in WR and is 0 in every other state. Back-to-back stores always have at least 2 cycles of `Mem_WE`=0 between pulses (DONE + IDLE).

## Timing
- Accept at edge N:
  - Error response: `RSP_VALID` in cycle N+1.
  - Load: `RSP_VALID` in cycle N+1+`RD_WAIT`.
  - SW: `Mem_WE` high in cycle N+1, `RSP_VALID` in cycle N+2.
  - SB/SH: `Mem_WE` high in cycle N+1+`RD_WAIT`, `RSP_VALID` in cycle N+2+`RD_WAIT`.
- Throughput: one request per response. `REQ_READY` is 0 from the accept edge until the IDLE cycle after DONE.
- `REQ_VALID` may stay high continuously. A new request is taken only in IDLE.
- Reset values, forced immediately on `RST` assertion with state = IDLE:
  - `RSP_VALID`, `RSP_ERR`, `Mem_WE` = 0.
  - `RSP_RDATA`, `IN_DATA_M` = 0; `ADDR_DATA_M` = 0.
  - `REQ_READY` = 0 while `RST`=1 and 1 in the first cycle after release.
- Reset mid-operation: the in-flight request is dropped and no response is issued. A reset during WR drops `Mem_WE` at once; the contents of that memory word are undefined.
- `RSP_RDATA` and `RSP_ERR` are valid only while `RSP_VALID`=1 and return to 0 in IDLE.

## Test plan
- Reset with `RD_WAIT`=1: assert `RST` during a WR cycle. Required: `Mem_WE`=0 within the same cycle, all outputs at reset values, no `RSP_VALID`. `REQ_READY`=1 one cycle after release.
- SW then LW, `REQ_ADDR`=0x0000_0010, data 0xDEAD_BEEF:
  - SW: `ADDR_DATA_M`=0x04 and `Mem_WE` high for 1 cycle; `RSP_VALID` at N+2.
  - LW: `RSP_RDATA`=0xDEAD_BEEF at N+2.
- SB then LB/LBU, word 0x04 preloaded with 0x1122_3344, SB addr 0x12 data 0x0000_0080:
  - Memory word becomes 0x1180_3344.
  - LB 0x12 returns 0xFFFF_FF80; LBU 0x12 returns 0x0000_0080.
- SH/LH, SH addr 0x16 data 0x0000_8001 to word 0x05 preloaded 0xAAAA_5555:
  - Word becomes 0x8001_5555.
  - LH 0x16 returns 0xFFFF_8001; LHU returns 0x0000_8001.
- Errors, each must give `RSP_ERR`=1 at N+1 with no `Mem_WE` pulse and memory unchanged:
  - LW at 0x0000_0012 (misaligned).
  - SH at 0x0000_0011 (misaligned).
  - SW at 0x0000_0400 (out of range).
  - Store with funct3=100 (invalid).
- `RD_WAIT`=3 with `REQ_VALID` held high over 3 back-to-back SB requests:
  - Each `RSP_VALID` at accept+5.
  - `Mem_WE` pulses separated by ≥2 low cycles.
  - `REQ_READY` low between accepts.
